// File: rtl/dn_mem_arbiter_pkg.sv
// Shared types for the download/CPU memory arbiter: FSM state encoding and
// the width of the download starvation counter.
package dn_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DNW,
        S_CPUW,
        S_CPUR,
        S_CPURD
    } arb_state_t;

    localparam int STARVE_W = 4;
    localparam int IOCTL_AW = 25;

endpackage

// File: rtl/dn_mem_arbiter_if.sv
// Bundles the ioctl download stream, CPU memory port, RAM port and download
// status signals; slave is the arbiter side, master is the system side.
interface dn_mem_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          ioctl_wait;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    logic          dn_busy;
    logic          dn_done;
    logic          dn_overrun;
    logic [AW:0]   dn_count;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_wait,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        output mem_addr, mem_din, mem_we,
        input  mem_dout,
        output dn_busy, dn_done, dn_overrun, dn_count
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_wait,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        input  mem_addr, mem_din, mem_we,
        output mem_dout,
        input  dn_busy, dn_done, dn_overrun, dn_count
    );

endinterface

// File: rtl/dn_mem_arbiter_hold_buf.sv
// Single-entry holding buffer for download bytes with a sticky overrun flag
// for strobes that arrive while the entry is still occupied.
module dn_hold_buf
    import dn_mem_arbiter_pkg::*;
#(
    parameter int         AW       = 17,
    parameter int         DW       = 8,
    parameter logic [7:0] DN_INDEX = 8'd0
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                wr,
    input  logic [7:0]          index,
    input  logic [IOCTL_AW-1:0] addr,
    input  logic [7:0]          data,
    input  logic                session_start,
    input  logic                take,
    output logic                full,
    output logic [AW-1:0]       buf_addr,
    output logic [DW-1:0]       buf_data,
    output logic                overrun
);

    logic match;

    // Bytes for another target or beyond the RAM window are invisible here.
    assign match = wr && (index == DN_INDEX) && ((addr >> AW) == '0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            overrun  <= 1'b0;
        end else begin
            if (take) begin
                full <= 1'b0;
            end else if (match && !full) begin
                full     <= 1'b1;
                buf_addr <= addr[AW-1:0];
                buf_data <= DW'(data);
            end
            if (session_start) overrun <= 1'b0;
            if (match && full) overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/dn_mem_arbiter.sv
// Shares one single-port RAM between the ioctl download stream and the CPU,
// with a starvation guard for buffered download bytes and session tracking.
module dn_mem_arbiter
    import dn_mem_arbiter_pkg::*;
#(
    parameter int         AW       = 17,
    parameter int         DW       = 8,
    parameter logic [7:0] DN_INDEX = 8'd0,
    parameter int         STARVE   = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    dn_mem_arbiter_if.slave bus
);

    arb_state_t          state;
    logic [STARVE_W-1:0] starve;
    logic                full;
    logic                overrun;
    logic [AW-1:0]       buf_addr;
    logic [DW-1:0]       buf_data;
    logic [AW-1:0]       mem_addr_q;
    logic [DW-1:0]       mem_din_q;
    logic                mem_we_q;
    logic                ack_q;
    logic                dl_q;
    logic                done_pend;
    logic                done_q;
    logic [AW:0]         count;
    logic                dn_grant;
    logic                rise;
    logic                fall;

    assign rise     = bus.ioctl_download && !dl_q;
    assign fall     = !bus.ioctl_download && dl_q;
    assign dn_grant = (state == S_IDLE) && full &&
                      (!bus.cpu_req || (starve == STARVE_W'(STARVE)));

    dn_hold_buf #(
        .AW       (AW),
        .DW       (DW),
        .DN_INDEX (DN_INDEX)
    ) u_hold_buf (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .wr            (bus.ioctl_wr),
        .index         (bus.ioctl_index),
        .addr          (bus.ioctl_addr),
        .data          (bus.ioctl_dout),
        .session_start (rise),
        .take          (dn_grant),
        .full          (full),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .overrun       (overrun)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            starve     <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            ack_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dn_grant) begin
                        state      <= S_DNW;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= buf_addr;
                        mem_din_q  <= buf_data;
                        starve     <= '0;
                    end else if (bus.cpu_req) begin
                        if (full) starve <= starve + 1'b1;
                        mem_addr_q <= bus.cpu_addr;
                        if (bus.cpu_we) begin
                            state     <= S_CPUW;
                            mem_we_q  <= 1'b1;
                            mem_din_q <= bus.cpu_din;
                            ack_q     <= 1'b1;
                        end else begin
                            state <= S_CPUR;
                        end
                    end
                end
                S_CPUR: begin
                    state <= S_CPURD;
                    ack_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A session that ends with a byte still buffered reports done only after
    // that byte has left the buffer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q      <= 1'b0;
            count     <= '0;
            done_pend <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            dl_q   <= bus.ioctl_download;
            done_q <= 1'b0;
            if (rise) begin
                count <= '0;
            end else if (state == S_DNW && count != '1) begin
                count <= count + 1'b1;
            end
            if (rise) begin
                done_pend <= 1'b0;
            end else if (fall || done_pend) begin
                if (!full) begin
                    done_q    <= 1'b1;
                    done_pend <= 1'b0;
                end else begin
                    done_pend <= 1'b1;
                end
            end
        end
    end

    // Ack and read data are masked while reset is asserted so an aborted
    // access never completes.
    assign bus.cpu_ack    = ack_q && !reset;
    assign bus.cpu_dout   = (state == S_CPURD && !reset) ? bus.mem_dout : '0;
    assign bus.ioctl_wait = full;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.dn_busy    = dl_q || full;
    assign bus.dn_done    = done_q;
    assign bus.dn_overrun = overrun;
    assign bus.dn_count   = count;

endmodule
